// File: rtl/data_mem_dma.sv
// Block-copy engine that drives the DataMem port: copies Length bytes from
// SrcAddr to DstAddr, one read cycle and one write cycle per byte.
module data_mem_dma #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic [AW-1:0] SrcAddr,
  input  logic [AW-1:0] DstAddr,
  input  logic [AW-1:0] Length,
  output logic          MemReadEn,
  output logic          MemWriteEn,
  output logic [AW-1:0] MemAddress,
  output logic [DW-1:0] MemWrData,
  input  logic [DW-1:0] MemRdData,
  output logic          Busy,
  output logic          Done,
  output logic [AW-1:0] Remaining
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] src_q, src_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [AW-1:0] rem_q, rem_d;
  logic [DW-1:0] buf_q, buf_d;

  // NOTE: every register is assigned its current value first, so paths that
  // do not update it hold state instead of inferring a latch.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    buf_d   = buf_q;
    unique case (state_q)
      S_IDLE: begin
        if (Start) begin
          src_d   = SrcAddr;
          dst_d   = DstAddr;
          rem_d   = Length;
          state_d = (Length != '0) ? S_READ : S_DONE;
        end
      end
      S_READ: begin
        buf_d   = MemRdData;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        // Pointers wrap modulo 2^AW; the memory commits the byte on this edge.
        src_d   = src_q + AW'(1);
        dst_d   = dst_q + AW'(1);
        rem_d   = rem_q - AW'(1);
        state_d = (rem_q == AW'(1)) ? S_DONE : S_READ;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge value, independent of statement order.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      buf_q   <= buf_d;
    end
  end

  // Outputs depend only on registered state, so an async reset clears them at once.
  always_comb begin
    MemReadEn  = 1'b0;
    MemWriteEn = 1'b0;
    MemAddress = '0;
    MemWrData  = '0;
    Busy       = 1'b0;
    Done       = 1'b0;
    unique case (state_q)
      S_READ: begin
        MemReadEn  = 1'b1;
        MemAddress = src_q;
        Busy       = 1'b1;
      end
      S_WRITE: begin
        MemWriteEn = 1'b1;
        MemAddress = dst_q;
        MemWrData  = buf_q;
        Busy       = 1'b1;
      end
      S_DONE:  Done = 1'b1;
      default: ;
    endcase
  end

  assign Remaining = rem_q;

endmodule

// File: tb/tb_data_mem_dma.sv
// Directed bench for data_mem_dma with a 256-byte behavioural DataMem.
module tb_data_mem_dma;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Start;
  logic [7:0] SrcAddr, DstAddr, Length;
  logic       MemReadEn, MemWriteEn;
  logic [7:0] MemAddress, MemWrData, MemRdData;
  logic       Busy, Done;
  logic [7:0] Remaining;

  logic [7:0] mem [256];

  int errors = 0;
  int checks = 0;

  // Per-cycle log of the last copy, index = cycles after the Start edge.
  int addr_log [64];
  int re_log   [64];
  int we_log   [64];
  int rem_log  [64];
  int done_cycle, busy_cycles, write_cycles, done_count, both_cycles;

  data_mem_dma #(.AW(8), .DW(8)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .SrcAddr    (SrcAddr),
    .DstAddr    (DstAddr),
    .Length     (Length),
    .MemReadEn  (MemReadEn),
    .MemWriteEn (MemWriteEn),
    .MemAddress (MemAddress),
    .MemWrData  (MemWrData),
    .MemRdData  (MemRdData),
    .Busy       (Busy),
    .Done       (Done),
    .Remaining  (Remaining)
  );

  always #5 Clk = ~Clk;

  assign MemRdData = mem[MemAddress];
  always @(posedge Clk) if (MemWriteEn) mem[MemAddress] <= MemWrData;

  task automatic check(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Called just after a negedge. Pulses Start, then logs `budget` cycles.
  // A second Start with other arguments is raised at cycle restart_at (>0).
  task automatic run_copy(input logic [7:0] src, input logic [7:0] dst,
                          input logic [7:0] len, input int budget, input int restart_at);
    SrcAddr = src; DstAddr = dst; Length = len; Start = 1'b1;
    done_cycle = -1; busy_cycles = 0; write_cycles = 0; done_count = 0; both_cycles = 0;
    @(posedge Clk);
    for (int c = 1; c <= budget; c++) begin
      @(negedge Clk);
      addr_log[c] = int'(MemAddress);
      re_log[c]   = int'(MemReadEn);
      we_log[c]   = int'(MemWriteEn);
      rem_log[c]  = int'(Remaining);
      if (Busy) busy_cycles++;
      if (MemWriteEn) write_cycles++;
      if (MemWriteEn && MemReadEn) both_cycles++;
      if (Done) begin
        done_count++;
        if (done_cycle < 0) done_cycle = c;
      end
      if (c == restart_at) begin
        SrcAddr = 8'h00; DstAddr = 8'hC0; Length = 8'h02; Start = 1'b1;
      end else begin
        Start = 1'b0;
        SrcAddr = 8'h00; DstAddr = 8'h00; Length = 8'h00;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    Reset = 1'b0; Start = 1'b0; SrcAddr = '0; DstAddr = '0; Length = '0;
    repeat (2) @(negedge Clk);

    check("reset_busy", int'(Busy), 0);
    check("reset_done", int'(Done), 0);
    check("reset_mem_en", int'({MemReadEn, MemWriteEn}), 0);
    check("reset_remaining", int'(Remaining), 0);
    Reset = 1'b1;
    @(negedge Clk);

    // Basic 4-byte copy.
    mem[8'h10] = 8'h11; mem[8'h11] = 8'h22; mem[8'h12] = 8'h33; mem[8'h13] = 8'h44;
    run_copy(8'h10, 8'h80, 8'd4, 12, 0);
    check("basic_done_cycle", done_cycle, 9);
    check("basic_done_count", done_count, 1);
    check("basic_busy_cycles", busy_cycles, 8);
    check("basic_no_overlap_en", both_cycles, 0);
    check("basic_rem_running", rem_log[1], 4);
    check("basic_rem_final", int'(Remaining), 0);
    for (int c = 1; c <= 8; c++) begin
      check($sformatf("basic_addr_c%0d", c), addr_log[c],
            (c % 2 == 1) ? (8'h10 + (c - 1) / 2) : (8'h80 + (c - 2) / 2));
      check($sformatf("basic_re_c%0d", c), re_log[c], c % 2);
      check($sformatf("basic_we_c%0d", c), we_log[c], 1 - c % 2);
    end
    check("basic_dst0", int'(mem[8'h80]), 8'h11);
    check("basic_dst1", int'(mem[8'h81]), 8'h22);
    check("basic_dst2", int'(mem[8'h82]), 8'h33);
    check("basic_dst3", int'(mem[8'h83]), 8'h44);

    // Zero length.
    run_copy(8'h10, 8'h84, 8'd0, 4, 0);
    check("zero_done_cycle", done_cycle, 1);
    check("zero_done_count", done_count, 1);
    check("zero_writes", write_cycles, 0);
    check("zero_busy", busy_cycles, 0);
    check("zero_mem_untouched", int'(mem[8'h84]), 0);

    // Wrap-around source.
    mem[8'hFE] = 8'hA1; mem[8'hFF] = 8'hB2; mem[8'h00] = 8'hC3; mem[8'h01] = 8'hD4;
    run_copy(8'hFE, 8'h40, 8'd4, 12, 0);
    check("wrap_done_cycle", done_cycle, 9);
    check("wrap_dst0", int'(mem[8'h40]), 8'hA1);
    check("wrap_dst1", int'(mem[8'h41]), 8'hB2);
    check("wrap_dst2", int'(mem[8'h42]), 8'hC3);
    check("wrap_dst3", int'(mem[8'h43]), 8'hD4);

    // Forward overlap replicates the first byte.
    mem[8'h20] = 8'h05; mem[8'h21] = 8'h00; mem[8'h22] = 8'h00; mem[8'h23] = 8'h00;
    run_copy(8'h20, 8'h21, 8'd3, 10, 0);
    check("overlap_21", int'(mem[8'h21]), 5);
    check("overlap_22", int'(mem[8'h22]), 5);
    check("overlap_23", int'(mem[8'h23]), 5);

    // Start while busy is ignored.
    mem[8'hC0] = 8'h77; mem[8'hC1] = 8'h77;
    run_copy(8'h10, 8'hA0, 8'd4, 14, 3);
    check("busy_start_done_cycle", done_cycle, 9);
    check("busy_start_done_count", done_count, 1);
    check("busy_start_writes", write_cycles, 4);
    check("busy_start_dst3", int'(mem[8'hA3]), 8'h44);
    check("busy_start_other_c0", int'(mem[8'hC0]), 8'h77);
    check("busy_start_other_c1", int'(mem[8'hC1]), 8'h77);

    // Async reset during the WRITE of byte 2 (cycle 4).
    SrcAddr = 8'h10; DstAddr = 8'h90; Length = 8'd4; Start = 1'b1;
    @(posedge Clk);
    for (int c = 1; c <= 4; c++) begin
      @(negedge Clk);
      Start = 1'b0;
    end
    check("rst_pre_we", int'(MemWriteEn), 1);
    check("rst_pre_rem", int'(Remaining), 3);
    #1 Reset = 1'b0;
    #1;
    check("rst_we_drop", int'(MemWriteEn), 0);
    check("rst_busy_drop", int'(Busy), 0);
    check("rst_rem_drop", int'(Remaining), 0);
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    begin
      int busy_seen = 0;
      repeat (4) begin
        @(negedge Clk);
        if (Busy || Done) busy_seen++;
      end
      check("rst_stays_idle", busy_seen, 0);
    end
    check("rst_byte1_kept", int'(mem[8'h90]), 8'h11);
    check("rst_byte2_unwritten", int'(mem[8'h91]), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_mem_dma.md
Name: data_mem_dma

Overview:
- Block-copy engine that acts as the requester on the DataMem port. It copies Length bytes from SrcAddr to DstAddr inside the 256-byte data memory.
- Sits beside the core datapath. A top-level mux, outside this block, hands the DataMem port to the engine while Busy=1.
- Uses DataMem timing: reads are combinational (data valid in the same cycle ReadEn/address are driven); writes commit on posedge Clk.

Parameters:
- AW, 8, address width (memory depth 2^AW)
- DW, 8, data width

Ports:
- Clk  input  1  system clock, posedge
- Reset  input  1  asynchronous, active-low reset (0 = reset)
- Start  input  1  request pulse; sampled only in IDLE
- SrcAddr  input  AW  first source byte address
- DstAddr  input  AW  first destination byte address
- Length  input  AW  byte count; 0 = no-op
- MemReadEn  output  1  to DataMem ReadEn
- MemWriteEn  output  1  to DataMem WriteEn
- MemAddress  output  AW  to DataMem DataAddress
- MemWrData  output  DW  to DataMem DataIn
- MemRdData  input  DW  from DataMem DataOut
- Busy  output  1  high in READ and WRITE states
- Done  output  1  one-cycle completion pulse
- Remaining  output  AW  bytes not yet written

Behaviour:
- Reset (Reset=0, asynchronous):
  - state=IDLE; src_ptr, dst_ptr, remaining and data_buf all go to 0.
  - All outputs go to 0 immediately, with no wait for a clock edge.
  - A copy in progress is abandoned. Bytes already written stay written; there is no rollback.
- States: IDLE, READ, WRITE, DONE. Outputs are decoded from the registered state and pointers only; there is no combinational path from Start to the outputs.
- IDLE:
  - All Mem* outputs are 0; Busy=0; Done=0.
  - At a posedge with Start=1: latch src_ptr=SrcAddr, dst_ptr=DstAddr, remaining=Length.
  - If Length!=0, go to READ; if Length=0, go to DONE.
- READ:
  - Drive MemReadEn=1, MemAddress=src_ptr, MemWriteEn=0.
  - At posedge: data_buf<=MemRdData, then go to WRITE.
- WRITE:
  - Drive MemWriteEn=1, MemAddress=dst_ptr, MemWrData=data_buf, MemReadEn=0.
  - At posedge (the memory commits the byte on the same edge): src_ptr+1, dst_ptr+1, remaining-1.
  - If remaining was 1, go to DONE; otherwise go to READ.
- DONE: Done=1 for exactly one cycle; Busy=0; Mem* outputs are 0. Next state is IDLE.
- Throughput: 2 cycles per byte. Start edge to the Done pulse takes 2N+1 cycles for N>0, and 1 cycle for N=0.
- Pointer arithmetic is modulo 2^AW: address 255+1 wraps to 0 silently, with no error flag.
- Overlap: the copy is strictly ascending, byte by byte.
  - If DstAddr is in (SrcAddr, SrcAddr+Length), source bytes are overwritten before they are read. The resulting replicate pattern is the defined behaviour.
  - If DstAddr=SrcAddr, memory is rewritten with its own content.
- Start is ignored in READ, WRITE and DONE, and is not queued. Inputs that change during a copy have no effect.
- MemReadEn and MemWriteEn are never high in the same cycle. When MemReadEn=0, MemAddress=0 and MemWrData=0 unless in WRITE.
- Remaining shows the latched count while running and 0 in IDLE/DONE after a full copy.

Test Plan:
- Basic copy: preload mem[0x10..0x13]=11,22,33,44; Start with Src=0x10, Dst=0x80, Len=4 -> mem[0x80..0x83]=11,22,33,44. Done pulses exactly 9 cycles after the Start edge. Busy is high for 8 cycles. The read/write alternation is checked cycle by cycle against MemAddress 0x10,0x80,0x11,0x81,...
- Zero length: Start with Len=0 -> Done on the next cycle. MemWriteEn never asserts and memory is unchanged.
- Wrap-around: Src=0xFE, Dst=0x40, Len=4 with mem[FE,FF,00,01]=A,B,C,D -> mem[0x40..0x43]=A,B,C,D.
- Overlap forward: mem[0x20]=5, mem[0x21..0x23]=0; Src=0x20, Dst=0x21, Len=3 -> mem[0x21..0x23]=5,5,5.
- Start while busy: a second Start with different args during a 4-byte copy -> ignored. The first copy completes unchanged, only one Done pulse occurs, and no extra writes happen.
- Reset mid-copy: assert Reset=0 asynchronously between clock edges while in WRITE of byte 2 -> MemWriteEn, Busy and Remaining drop to 0 before the next edge. Byte 2 is not written and byte 1 is retained. After release, the FSM stays IDLE until a new Start.
